// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the camera-init ROM and issues one SCCB write per entry,
// honouring the FFF0 delay and FFFF end-of-table markers.
module ov7670_config_sequencer #(
   parameter int ADDR_W       = 8,
   parameter int DELAY_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_clk_en,
   input  logic [15:0]       rom_data,
   output logic              sccb_req,
   output logic [7:0]        sccb_reg,
   output logic [7:0]        sccb_val,
   input  logic              sccb_ready,
   input  logic              sccb_done,
   input  logic              sccb_nack,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        cmd_count
);
   localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT_DONE, DELAY, NEXT} state_t;

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               en_q, req_q, busy_q, done_q, err_q;
   logic [7:0]         reg_q, val_q, cnt_q;
   logic [DLY_W-1:0]   dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         en_q    <= 1'b0;
         req_q   <= 1'b0;
         reg_q   <= '0;
         val_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         dly_q   <= '0;
      end else begin
         // ROM enable is pulsed on entry to FETCH so it is high for that cycle only
         en_q <= 1'b0;
         case (state_q)
            IDLE:
               if (start) begin
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  en_q    <= 1'b1;
                  state_q <= FETCH;
               end
            FETCH: state_q <= DECODE;
            DECODE:
               if (rom_data == 16'hFFFF) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (rom_data == 16'hFFF0) begin
                  dly_q   <= DLY_W'(DELAY_CYCLES - 1);
                  state_q <= DELAY;
               end else if (rom_data[15:8] == 8'hFE) begin
                  state_q <= NEXT;
               end else begin
                  reg_q   <= rom_data[15:8];
                  val_q   <= rom_data[7:0];
                  req_q   <= 1'b1;
                  state_q <= SEND;
               end
            SEND:
               if (sccb_ready) begin
                  req_q   <= 1'b0;
                  state_q <= WAIT_DONE;
               end
            WAIT_DONE:
               if (sccb_done) begin
                  if (sccb_nack) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 8'(cnt_q != 8'hFF);
                     state_q <= NEXT;
                  end
               end
            DELAY:
               if (dly_q == '0) state_q <= NEXT;
               else dly_q <= dly_q - DLY_W'(1);
            NEXT:
               if (&addr_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  en_q    <= 1'b1;
                  state_q <= FETCH;
               end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr   = addr_q;
   assign rom_clk_en = en_q;
   assign sccb_req   = req_q;
   assign sccb_reg   = reg_q;
   assign sccb_val   = val_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = err_q;
   assign cmd_count  = cnt_q;
endmodule
